mix_columns_iter: RTL and testbench
===================================

# mix_columns_iter

Column-serial AES-128 encryption MixColumns stage. It sits directly downstream of the ShiftRows register and consumes that stage's 128-bit column-major state. It multiplies each state column by the fixed GF(2^8) circulant matrix and presents the result through a valid/ready handshake to the AddRoundKey stage. A per-block bypass input passes the state through unchanged for the final round.

## Interface
- COLS_PER_CYCLE, 1: columns processed per clock while busy. Legal values are 1, 2 and 4; any other value is an elaboration error. K = 4/COLS_PER_CYCLE.
- clk  input  1  single clock; all flops are rising-edge.
- rst_n  input  1  reset, asynchronous and active-low.
- in_valid  input  1  in_state and in_bypass are valid.
- in_ready  output  1  block can accept; high only in IDLE.
- in_state  input  128  ShiftRows output, column-major layout:
  - column c = bits [127-32c -: 32];
  - row r of column c = bits [127-32c-8r -: 8].
- in_bypass  input  1  when set, copy the state unchanged (final round).
- out_valid  output  1  out_state holds a finished block.
- out_ready  input  1  downstream accepts out_state.
- out_state  output  128  result, same layout as in_state.
- busy  output  1  high in BUSY.

## Operation
- FSM states: IDLE, BUSY, DONE. Reset state is IDLE.
- IDLE:
  - in_ready=1.
  - On in_valid: capture in_state into the working register and clear the column counter.
  - in_bypass=0: go to BUSY.
  - in_bypass=1: load out_state with in_state directly and go to DONE.
- BUSY:
  - Each cycle, transform column group g (columns g·COLS_PER_CYCLE … +COLS_PER_CYCLE-1) and write the result into the same column positions of out_state.
  - Columns not yet processed in out_state are don't-care until DONE.
  - After group K-1 is written, go to DONE.
- DONE:
  - out_valid=1; out_state is stable.
  - On out_ready: go to IDLE.
  - No new input is accepted in DONE (in_ready=0).
- Column transform, per column bytes a0..a3 (row 0..3):
  - b0=2a0^3a1^a2^a3
  - b1=a0^2a1^3a2^a3
  - b2=a0^a1^2a2^3a3
  - b3=3a0^a1^a2^2a3
- Arithmetic:
  - 2x = {x[6:0],1'b0} ^ (x[7] ? 8'h1b : 8'h00).
  - 3x = 2x ^ x.
  - All arithmetic is 8-bit with no carries.
- Column counter is 2 bits and counts 0..K-1. It wraps to 0 only on re-entry to BUSY, never by overflow.
- in_bypass is sampled only at the accept edge and has no effect at any other time.
- Inputs are ignored outside IDLE; in_state may change freely there.
- Reset assertion, async and at any time including mid-BUSY or in DONE:
  - aborts the block and forces state=IDLE;
  - out_state=128'h0, out_valid=0, busy=0, counter=0.
  - A partially processed block is discarded.
- Reset values: in_ready=1 (decoded from IDLE; no capture occurs while rst_n=0), out_valid=0, busy=0, out_state=0.

## Timing
- Accept edge E0 is the rising edge where in_valid & in_ready.
- Non-bypass:
  - busy is high in the K cycles after E0.
  - Groups are written at edges E1..EK.
  - out_valid rises after EK, i.e. K cycles after accept: COLS=1 gives 4, COLS=2 gives 2, COLS=4 gives 1.
- Bypass: out_valid is high in the cycle immediately after E0.
- out_valid and out_state hold unchanged until the edge where out_valid & out_ready. Both drop after that edge.
- in_ready is high again in the cycle after the output handshake. The earliest next accept is that edge.
- Throughput: one block per K+2 cycles when out_ready is tied high.
- out_ready may be held high in advance; it has effect only in DONE.
- in_valid & out_ready asserted together in DONE: the output completes and the input is not accepted; it must be held until in_ready.

## Test plan
- Single column (COLS=1), input column 0 = db 13 53 45 -> output column 0 = 8e 4d a1 bc. Also f2 0a 22 5c -> 9f dc 58 9d, and 01 01 01 01 / c6 c6 c6 c6 pass unchanged.
- FIPS-197 round 1, in_state = d4bf5d30_e0b452ae_b84111f1_1e2798e5, bypass=0 -> out_state = 046681e5_e0cb199a_48f8d37a_2806264c. out_valid rises exactly 4, 2 and 1 cycles after accept for COLS = 1, 2, 4.
- Bypass: same in_state with in_bypass=1 -> out_state equals in_state; out_valid is high the cycle after accept; busy never asserts.
- Backpressure: hold out_ready=0 for 10 cycles in DONE -> out_state and out_valid stable, in_ready=0. Toggle in_state/in_valid during this window -> no effect. Release out_ready -> a single handshake, then IDLE.
- Reset mid-operation: assert rst_n=0 asynchronously after E2 of a COLS=1 block -> out_valid=0, out_state=0, busy=0 immediately. After release, a new block (2d 26 31 4c in column 0) -> 4d 7e bd f8, with no trace of the aborted block.
- Back-to-back: 8 random blocks with in_valid and out_ready tied high, checked against a reference model -> all match, accepts spaced exactly K+2 cycles apart.

Source files
------------

// File: rtl/mix_columns_iter.sv
// Column-serial AES MixColumns stage with per-block bypass for the final round.
// Accepts one 128-bit column-major state in IDLE. It transforms COLS_PER_CYCLE
// columns per clock while BUSY, then holds the result in DONE until it is taken.

// One MixColumns column: b = circulant(2,3,1,1) * a over GF(2^8).
module mix_col (
  input  logic [31:0] col_i,
  output logic [31:0] col_o
);
  logic [7:0] a0, a1, a2, a3;
  logic [7:0] d0, d1, d2, d3;

  // GF(2^8) doubling with the AES reduction polynomial.
  function automatic logic [7:0] xt(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

  assign {a0, a1, a2, a3} = col_i;
  assign d0 = xt(a0);
  assign d1 = xt(a1);
  assign d2 = xt(a2);
  assign d3 = xt(a3);

  // 3x is written as 2x ^ x.
  assign col_o = {d0 ^ (d1 ^ a1) ^ a2 ^ a3,
                  a0 ^ d1 ^ (d2 ^ a2) ^ a3,
                  a0 ^ a1 ^ d2 ^ (d3 ^ a3),
                  (d0 ^ a0) ^ a1 ^ a2 ^ d3};
endmodule

module mix_columns_iter #(
  parameter int COLS_PER_CYCLE = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_state,
  input  logic         in_bypass,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_state,
  output logic         busy
);
  localparam int K = 4 / COLS_PER_CYCLE;

  if (!(COLS_PER_CYCLE == 1 || COLS_PER_CYCLE == 2 || COLS_PER_CYCLE == 4)) begin : g_bad_cols
    $error("mix_columns_iter: COLS_PER_CYCLE must be 1, 2 or 4");
  end

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

  state_e            state_q;
  logic [1:0]        cnt_q;
  // Column c sits in bits [127-32c -: 32], which is packed element 3-c (= ~c).
  logic [3:0][31:0]  work_q, out_q, out_d;

  logic [COLS_PER_CYCLE-1:0][1:0]  col_idx;
  logic [COLS_PER_CYCLE-1:0][31:0] col_in, col_out;

  // One transform lane per column handled in a cycle.
  for (genvar j = 0; j < COLS_PER_CYCLE; j++) begin : g_lane
    assign col_idx[j] = 2'((int'(cnt_q) * COLS_PER_CYCLE + j) % 4);
    assign col_in[j]  = work_q[~col_idx[j]];
    mix_col u_mix (.col_i(col_in[j]), .col_o(col_out[j]));
  end

  // Merge the current group's results into the output register image.
  always_comb begin
    out_d = out_q;
    for (int j = 0; j < COLS_PER_CYCLE; j++)
      out_d[~col_idx[j]] = col_out[j];
  end

  // Control FSM plus the working/output registers; reset discards any block in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      work_q  <= '0;
      out_q   <= '0;
    end else begin
      case (state_q)
        IDLE: if (in_valid) begin
          work_q <= in_state;
          cnt_q  <= '0;
          if (in_bypass) begin
            out_q   <= in_state;
            state_q <= DONE;
          end else begin
            state_q <= BUSY;
          end
        end
        BUSY: begin
          out_q <= out_d;
          // Counter parks at K-1; it is only cleared by the next accept.
          if (cnt_q == 2'(K - 1)) state_q <= DONE;
          else                    cnt_q   <= cnt_q + 2'd1;
        end
        DONE: if (out_ready) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign busy      = (state_q == BUSY);
  assign out_valid = (state_q == DONE);
  assign out_state = out_q;
endmodule

// File: tb/tb_mix_columns_iter.sv
module tb_mix_columns_iter;
  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic [127:0] in_state = '0;
  logic         in_bypass = 1'b0;
  logic         out_ready = 1'b0;

  logic         in_ready1, out_valid1, busy1;
  logic         in_ready2, out_valid2, busy2;
  logic         in_ready4, out_valid4, busy4;
  logic [127:0] out_state1, out_state2, out_state4;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mix_columns_iter #(.COLS_PER_CYCLE(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready1),
    .in_state(in_state), .in_bypass(in_bypass), .out_valid(out_valid1),
    .out_ready(out_ready), .out_state(out_state1), .busy(busy1));
  mix_columns_iter #(.COLS_PER_CYCLE(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready2),
    .in_state(in_state), .in_bypass(in_bypass), .out_valid(out_valid2),
    .out_ready(out_ready), .out_state(out_state2), .busy(busy2));
  mix_columns_iter #(.COLS_PER_CYCLE(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready4),
    .in_state(in_state), .in_bypass(in_bypass), .out_valid(out_valid4),
    .out_ready(out_ready), .out_state(out_state4), .busy(busy4));

  typedef struct {
    logic [127:0] st;
    logic         byp;
    logic [127:0] exp;
  } vec_t;
  vec_t vt[6];

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // Reference MixColumns straight from the GF(2^8) definition.
  function automatic logic [7:0] gm2(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction
  function automatic logic [127:0] ref_mix(input logic [127:0] s);
    logic [127:0] r;
    logic [7:0] a[4];
    for (int c = 0; c < 4; c++) begin
      for (int k = 0; k < 4; k++) a[k] = s[127-32*c-8*k -: 8];
      r[127-32*c    -: 8] = gm2(a[0]) ^ gm2(a[1]) ^ a[1] ^ a[2] ^ a[3];
      r[127-32*c-8  -: 8] = a[0] ^ gm2(a[1]) ^ gm2(a[2]) ^ a[2] ^ a[3];
      r[127-32*c-16 -: 8] = a[0] ^ a[1] ^ gm2(a[2]) ^ gm2(a[3]) ^ a[3];
      r[127-32*c-24 -: 8] = gm2(a[0]) ^ a[0] ^ a[1] ^ a[2] ^ gm2(a[3]);
    end
    return r;
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Accept one block on all three instances with out_ready low, check latency,
  // busy profile and result, then complete the handshake. Starts/ends at negedge.
  task automatic run_block(input string nm, input logic [127:0] st, input logic byp,
                           input logic [127:0] exp);
    int l1, l2, l4, nb;
    l1 = -1; l2 = -1; l4 = -1; nb = 0;
    out_ready = 1'b0;
    in_state = st; in_bypass = byp; in_valid = 1'b1;
    chk({nm, " in_ready before accept"}, in_ready1, 1'b1);
    @(posedge clk);           // E0
    @(negedge clk);
    in_valid = 1'b0; in_bypass = 1'b0; in_state = rnd128();
    for (int t = 0; t < 8; t++) begin
      if (out_valid1 && l1 < 0) l1 = t;
      if (out_valid2 && l2 < 0) l2 = t;
      if (out_valid4 && l4 < 0) l4 = t;
      if (busy1) nb++;
      @(posedge clk);
      @(negedge clk);
    end
    chk({nm, " latency C1"}, 128'(l1), byp ? 128'd0 : 128'd4);
    chk({nm, " latency C2"}, 128'(l2), byp ? 128'd0 : 128'd2);
    chk({nm, " latency C4"}, 128'(l4), byp ? 128'd0 : 128'd1);
    chk({nm, " busy cycles C1"}, 128'(nb), byp ? 128'd0 : 128'd4);
    chk({nm, " out_state C1"}, out_state1, exp);
    chk({nm, " out_state C2"}, out_state2, exp);
    chk({nm, " out_state C4"}, out_state4, exp);
    chk({nm, " in_ready in DONE"}, in_ready1, 1'b0);
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    chk({nm, " out_valid after handshake"}, {out_valid1, out_valid2, out_valid4}, 3'b000);
    chk({nm, " in_ready after handshake"}, {in_ready1, in_ready2, in_ready4}, 3'b111);
  endtask

  initial begin
    logic [127:0] q[$];
    logic [127:0] cur, hold;
    int last_acc, nacc, nout;
    logic acc;

    vt[0] = '{128'hdb135345_f20a225c_01010101_c6c6c6c6, 1'b0,
              128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6};
    vt[1] = '{128'h2d26314c_db135345_c6c6c6c6_f20a225c, 1'b0,
              128'h4d7ebdf8_8e4da1bc_c6c6c6c6_9fdc589d};
    vt[2] = '{128'hd4bf5d30_e0b452ae_b84111f1_1e2798e5, 1'b0,
              128'h046681e5_e0cb199a_48f8d37a_2806264c};
    vt[3] = '{128'hd4bf5d30_e0b452ae_b84111f1_1e2798e5, 1'b1,
              128'hd4bf5d30_e0b452ae_b84111f1_1e2798e5};
    vt[4] = '{128'h01010101_c6c6c6c6_f20a225c_db135345, 1'b0,
              128'h01010101_c6c6c6c6_9fdc589d_8e4da1bc};
    vt[5] = '{128'hdb135345_f20a225c_01010101_c6c6c6c6, 1'b1,
              128'hdb135345_f20a225c_01010101_c6c6c6c6};

    // Reset values while held in reset.
    in_valid = 1'b1;
    in_state = 128'hdead;
    repeat (2) @(negedge clk);
    chk("reset in_ready", {in_ready1, in_ready2, in_ready4}, 3'b111);
    chk("reset out_valid", {out_valid1, out_valid2, out_valid4}, 3'b000);
    chk("reset busy", {busy1, busy2, busy4}, 3'b000);
    chk("reset out_state", out_state1 | out_state2 | out_state4, 128'h0);
    in_valid = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);

    // Table-driven vectors.
    for (int i = 0; i < 6; i++)
      run_block($sformatf("vec%0d", i), vt[i].st, vt[i].byp, vt[i].exp);

    // Backpressure: 10 cycles in DONE with inputs toggling.
    out_ready = 1'b0;
    in_state = vt[2].st; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (4) @(negedge clk);
    hold = out_state1;
    chk("bp result", hold, vt[2].exp);
    for (int t = 0; t < 10; t++) begin
      in_valid = t[0];
      in_bypass = t[1];
      in_state = rnd128();
      @(posedge clk);
      @(negedge clk);
      if (out_valid1 !== 1'b1 || out_state1 !== hold || in_ready1 !== 1'b0)
        chk($sformatf("bp hold t%0d", t), {out_valid1, in_ready1, out_state1}, {2'b10, hold});
      else n_vec++;
    end
    // in_valid and out_ready together in DONE: output completes, input waits.
    in_valid = 1'b1; in_bypass = 1'b0; in_state = vt[0].st; out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    chk("bp release valid/busy/ready", {out_valid1, busy1, in_ready1}, 3'b001);
    @(posedge clk);           // accepted here
    @(negedge clk);
    in_valid = 1'b0;
    chk("accept after release busy", busy1, 1'b1);
    repeat (4) @(negedge clk);
    chk("accept after release result", {out_valid1, out_state1}, {1'b1, vt[0].exp});
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;

    // Asynchronous reset after E2 of a COLS=1 block.
    in_state = vt[2].st; in_valid = 1'b1;
    @(posedge clk);           // E0
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);           // E1
    @(posedge clk);           // E2
    #2 rst_n = 1'b0;
    #1;
    chk("async rst out_valid/busy", {out_valid1, busy1, in_ready1}, 3'b001);
    chk("async rst out_state", out_state1, 128'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_block("post-reset", vt[1].st, 1'b0, vt[1].exp);

    // Back-to-back with in_valid and out_ready tied high (checked on COLS=1).
    in_valid = 1'b1; out_ready = 1'b1; in_bypass = 1'b0;
    cur = rnd128(); in_state = cur;
    last_acc = -1; nacc = 0; nout = 0;
    for (int cyc = 0; cyc < 200 && nout < 8; cyc++) begin
      if (out_valid1) begin
        if (q.size() == 0) chk("b2b unexpected output", out_state1, 128'hx);
        else chk($sformatf("b2b out%0d", nout), out_state1, q.pop_front());
        nout++;
      end
      acc = in_ready1 && in_valid;
      if (acc) begin
        q.push_back(ref_mix(cur));
        if (last_acc >= 0) chk($sformatf("b2b spacing%0d", nacc), 128'(cyc - last_acc), 128'd6);
        last_acc = cyc;
        nacc++;
      end
      @(posedge clk);
      @(negedge clk);
      if (acc) begin cur = rnd128(); in_state = cur; end
      if (nacc == 8) in_valid = 1'b0;
    end
    chk("b2b outputs seen", 128'(nout), 128'd8);
    out_ready = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
